// File: rtl/rca_shift_add_mult4.sv
// Sequential 4x4 unsigned shift-add multiplier driving an external combinational 4-bit RCA.
// Optional RCA self-check enabled by defining RCA_CHECK_EN (adder_fault tied low otherwise).
`timescale 1ns/1ps
module rca_shift_add_mult4 (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] A_in,
  input  logic [3:0] B_in,
  output logic       busy,
  output logic       done,
  output logic [7:0] product,
  output logic [3:0] A_data,
  output logic [3:0] B_data,
  output logic       c_in,
  input  logic [3:0] sum,
  input  logic       c_out,
  output logic       adder_fault
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  m_q, m_d;
  logic [3:0]  q_q, q_d;
  logic [3:0]  acc_q, acc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  product_q, product_d;
  logic [7:0]  shifted;
  logic        accept;

  // {c_out,sum,Q} shifted right by one: new {ACC,Q}
  assign shifted = {c_out, sum, q_q[3:1]};
  assign accept  = start && (state_q != RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      m_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          m_d     = A_in;
          q_d     = B_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        {acc_d, q_d} = shifted;
        cnt_d        = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          product_d = shifted;
          state_d   = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;
  assign A_data  = acc_q;
  assign B_data  = ((state_q == RUN) && q_q[0]) ? m_q : '0;
  assign c_in    = 1'b0;

`ifdef RCA_CHECK_EN
  logic [4:0] expect_sum;
  logic       fault_q, fault_d;

  // Observe-only: the datapath always consumes the RCA outputs
  assign expect_sum = {1'b0, A_data} + {1'b0, B_data} + {4'b0, c_in};

  always_comb begin
    fault_d = fault_q;
    if ((state_q == RUN) && ({c_out, sum} != expect_sum)) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign adder_fault = fault_q;
`else
  assign adder_fault = 1'b0;
`endif

endmodule

// File: tb/tb_rca_shift_add_mult4.sv
// Directed bench for rca_shift_add_mult4 with a behavioural RCA and sum[1] stuck-at-0 fault injection.
`timescale 1ns/1ps
module tb_rca_shift_add_mult4;

`ifdef RCA_CHECK_EN
  localparam bit EXP_FAULT = 1'b1;
`else
  localparam bit EXP_FAULT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] A_in, B_in;
  logic       busy, done;
  logic [7:0] product;
  logic [3:0] A_data, B_data;
  logic       c_in;
  logic [3:0] sum;
  logic       c_out;
  logic       adder_fault;
  logic [4:0] rca;
  bit         fault_on = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rca   = {1'b0, A_data} + {1'b0, B_data} + {4'b0, c_in};
  assign sum   = fault_on ? (rca[3:0] & 4'b1101) : rca[3:0];
  assign c_out = rca[4];

  rca_shift_add_mult4 dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .A_in       (A_in),
    .B_in       (B_in),
    .busy       (busy),
    .done       (done),
    .product    (product),
    .A_data     (A_data),
    .B_data     (B_data),
    .c_in       (c_in),
    .sum        (sum),
    .c_out      (c_out),
    .adder_fault(adder_fault)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; steps negedges until done is seen or the bound expires.
  task automatic wait_done(input string name, output int cyc);
    bit ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk({name, "_done_seen"}, int'(ok), 1);
  endtask

  task automatic run_op(input string nm, input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] ep, input bit bz, input bit cs, input bit ef);
    int  nbusy = 0;
    bit  ok = 1'b0, bnz = 1'b0, cseen = 1'b0, cin_bad = 1'b0;
    @(negedge clk);
    A_in = a; B_in = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) begin
        nbusy++;
        if (B_data != 4'h0) bnz = 1'b1;
        if (c_out) cseen = 1'b1;
        if (c_in) cin_bad = 1'b1;
      end
      @(negedge clk);
    end
    chk({nm, "_done_seen"}, int'(ok), 1);
    chk({nm, "_busy_cycles"}, nbusy, 4);
    chk({nm, "_product"}, int'(product), int'(ep));
    chk({nm, "_c_in"}, int'(cin_bad), 0);
    chk({nm, "_cout_seen"}, int'(cseen), int'(cs));
    if (bz) chk({nm, "_bdata_zero"}, int'(bnz), 0);
    chk({nm, "_adder_fault"}, int'(adder_fault), int'(ef));
    @(negedge clk);
    chk({nm, "_done_pulse"}, int'(done), 0);
    chk({nm, "_idle"}, int'(busy), 0);
    chk({nm, "_product_hold"}, int'(product), int'(ep));
  endtask

  typedef struct {
    string      nm;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
    bit         bz;
    bit         cs;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int  cyc;
    bit  any_done;

    tbl[0] = '{"m3x5",   4'd3,  4'd5,  8'h0F, 1'b0, 1'b0};
    tbl[1] = '{"m15x15", 4'd15, 4'd15, 8'hE1, 1'b0, 1'b1};
    tbl[2] = '{"m10x0",  4'd10, 4'd0,  8'h00, 1'b1, 1'b0};
    tbl[3] = '{"m0x9",   4'd0,  4'd9,  8'h00, 1'b0, 1'b0};
    tbl[4] = '{"m12x13", 4'd12, 4'd13, 8'h9C, 1'b0, 1'b1};

    reset = 1'b1; start = 1'b0; A_in = '0; B_in = '0;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_product", int'(product), 0);
    chk("rst_A_data", int'(A_data), 0);
    chk("rst_B_data", int'(B_data), 0);
    chk("rst_c_in", int'(c_in), 0);
    chk("rst_fault", int'(adder_fault), 0);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) run_op(tbl[i].nm, tbl[i].a, tbl[i].b, tbl[i].p, tbl[i].bz, tbl[i].cs, 1'b0);

    // Start pulse during RUN (sampled at E2) must be ignored
    @(negedge clk);
    A_in = 4'd2; B_in = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A_in = 4'd15; B_in = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_busy", int'(busy), 1);
    wait_done("ign", cyc);
    chk("ign_latency", cyc, 2);
    chk("ign_product", int'(product), 8'h0E);

    // Back-to-back with start held high
    @(negedge clk);
    A_in = 4'd6; B_in = 4'd6; start = 1'b1;
    @(negedge clk);
    wait_done("b2b1", cyc);
    chk("b2b1_latency", cyc, 4);
    chk("b2b1_product", int'(product), 8'h24);
    @(negedge clk);
    chk("b2b_restart_busy", int'(busy), 1);
    chk("b2b_restart_done", int'(done), 0);
    wait_done("b2b2", cyc);
    chk("b2b2_spacing", cyc + 1, 5);
    chk("b2b2_product", int'(product), 8'h24);
    start = 1'b0;
    @(negedge clk);
    chk("b2b_idle_busy", int'(busy), 0);
    chk("b2b_idle_done", int'(done), 0);

    // Asynchronous reset after E2 aborts the operation
    @(negedge clk);
    A_in = 4'd9; B_in = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort_pre_busy", int'(busy), 1);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_product", int'(product), 0);
    chk("abort_A_data", int'(A_data), 0);
    @(negedge clk);
    reset = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done || busy) any_done = 1'b1;
    end
    chk("abort_no_done", int'(any_done), 0);
    run_op("after_abort", 4'd4, 4'd4, 8'h10, 1'b0, 1'b0, 1'b0);

    // RCA sum[1] stuck-at-0
    fault_on = 1'b1;
    @(negedge clk);
    A_in = 4'd3; B_in = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("flt", cyc);
    chk("flt_flag", int'(adder_fault), int'(EXP_FAULT));
    fault_on = 1'b0;
    run_op("flt_sticky", 4'd3, 4'd5, 8'h0F, 1'b0, 1'b0, EXP_FAULT);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("flt_reset_clear", int'(adder_fault), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
